// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes and the memory-stage FSM states.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'd0;
  localparam logic [3:0] INOP    = 4'd1;
  localparam logic [3:0] IRRMOVQ = 4'd2;
  localparam logic [3:0] IIRMOVQ = 4'd3;
  localparam logic [3:0] IRMMOVQ = 4'd4;
  localparam logic [3:0] IMRMOVQ = 4'd5;
  localparam logic [3:0] IOPQ    = 4'd6;
  localparam logic [3:0] IJXX    = 4'd7;
  localparam logic [3:0] ICALL   = 4'd8;
  localparam logic [3:0] IRET    = 4'd9;
  localparam logic [3:0] IPUSHQ  = 4'd10;
  localparam logic [3:0] IPOPQ   = 4'd11;

  localparam logic [1:0] SAOK = 2'd0;
  localparam logic [1:0] SHLT = 2'd1;
  localparam logic [1:0] SADR = 2'd2;
  localparam logic [1:0] SINS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_t;

  function automatic logic is_write_op(input logic [3:0] ic);
    return (ic == IRMMOVQ) || (ic == IPUSHQ) || (ic == ICALL);
  endfunction

  function automatic logic is_read_op(input logic [3:0] ic);
    return (ic == IMRMOVQ) || (ic == IPOPQ) || (ic == IRET);
  endfunction

endpackage

// File: rtl/y86_dmem.sv
// Single-port byte-wide data RAM: synchronous write, combinational read.
module y86_dmem #(
  parameter int MEM_BYTES = 1024,
  parameter int AW        = 10
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_din,
  output logic [7:0]    o_dout
);

  logic [7:0] r_mem [MEM_BYTES];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_din;
    end
  end

  assign o_dout = r_mem[i_addr];

endmodule

// File: rtl/memory_stage.sv
// Y86-64 memory stage: starts on a flag3 rising edge, moves 8 bytes little-endian one per
// clock, and raises flag4 when done (1 edge after capture for non-access or faulting ops).
module memory_stage
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int AW        = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flag3,
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  output logic [63:0] valM,
  output logic [1:0]  stat,
  output logic        dmem_error,
  output logic        flag4
);

  mem_state_t    r_state;
  logic          r_flag3_q;
  logic          r_is_write;
  logic          r_no_xfer;
  logic [2:0]    r_k;
  logic [AW-1:0] r_addr;
  logic [63:0]   r_wdata;

  logic          w_start;
  logic          w_accept;
  logic          w_wr;
  logic          w_rd;
  logic [63:0]   w_addr64;
  logic          w_addr_ok;
  logic [AW-1:0] w_mem_addr;
  logic          w_we;
  logic [7:0]    w_din;
  logic [7:0]    w_dout;
  logic [5:0]    w_bit;

  assign w_start   = flag3 & ~r_flag3_q;
  assign w_accept  = w_start & (r_state != ST_ACCESS);
  assign w_wr      = is_write_op(icode);
  assign w_rd      = is_read_op(icode);
  assign w_addr64  = ((icode == IPOPQ) || (icode == IRET)) ? valA : valE;
  // Full 64-bit compare so addresses with stray upper bits never alias into the RAM.
  assign w_addr_ok = (w_addr64 <= 64'(MEM_BYTES - 8));

  assign w_bit      = {r_k, 3'b000};
  assign w_mem_addr = r_addr + {{(AW-3){1'b0}}, r_k};
  assign w_din      = r_wdata[w_bit +: 8];
  // Reset blocks the byte in flight, so an aborted store leaves only bytes 0..k-1 written.
  assign w_we       = (r_state == ST_ACCESS) & ~r_no_xfer & r_is_write & ~reset;

  y86_dmem #(
    .MEM_BYTES (MEM_BYTES),
    .AW        (AW)
  ) u_dmem (
    .clk    (clk),
    .i_we   (w_we),
    .i_addr (w_mem_addr),
    .i_din  (w_din),
    .o_dout (w_dout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_flag3_q  <= 1'b0;
      r_is_write <= 1'b0;
      r_no_xfer  <= 1'b0;
      r_k        <= 3'd0;
      r_addr     <= '0;
      r_wdata    <= 64'd0;
      valM       <= 64'd0;
      stat       <= SAOK;
      dmem_error <= 1'b0;
      flag4      <= 1'b0;
    end else begin
      r_flag3_q <= flag3;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_state    <= ST_ACCESS;
            r_k        <= 3'd0;
            r_addr     <= w_addr64[AW-1:0];
            r_wdata    <= (icode == ICALL) ? valP : valA;
            r_is_write <= w_wr;
            flag4      <= 1'b0;
            valM       <= 64'd0;
            dmem_error <= 1'b0;
            if (w_wr || w_rd) begin
              if (w_addr_ok) begin
                r_no_xfer <= 1'b0;
                stat      <= SAOK;
              end else begin
                r_no_xfer  <= 1'b1;
                stat       <= SADR;
                dmem_error <= 1'b1;
              end
            end else begin
              r_no_xfer <= 1'b1;
              if (icode == IHALT) begin
                stat <= SHLT;
              end else if (icode >= 4'd12) begin
                stat <= SINS;
              end else begin
                stat <= SAOK;
              end
            end
          end
        end
        ST_ACCESS: begin
          // Non-transferring ops spend exactly one cycle here so flag4 rises one edge after capture.
          if (r_no_xfer) begin
            r_state <= ST_DONE;
            flag4   <= 1'b1;
          end else begin
            if (!r_is_write) begin
              valM[w_bit +: 8] <= w_dout;
            end
            r_k <= r_k + 3'd1;
            if (r_k == 3'd7) begin
              r_state <= ST_DONE;
              flag4   <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
